pll_rst_sequencer: RTL and testbench
====================================

// Module: pll_rst_sequencer
// PURPOSE
//  Controller for the clock-generation PLL's RST/LOCK pair. Drives the PLL reset, waits for and qualifies lock,
//  retries on timeout, and releases a registered active-low reset to the video-pipeline logic.
//  Runs on the board oscillator clock, which is free-running and does not come from the PLL.
//  Escalates to a sticky fault after repeated lock failures.
// PARAMETERS
//  RST_PULSE_CYC    16      cycles pll_rst_o is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYC 250000  max cycles to wait for synchronised lock after reset deasserts
//  LOCK_STABLE_CYC  1024    consecutive high-lock cycles needed to declare lock
//  MAX_RETRY        3       failed attempts allowed before entering FAULT (1..15)
//  RELEASE_DLY_CYC  64      cycles between pll_locked_o rising and user_rst_n_o rising
// PORTS
//  clk            in   1  free-running reference clock; only clock of the block
//  rst_n          in   1  asynchronous active-low reset
//  pll_lock_i     in   1  PLL LOCK output; asynchronous to clk
//  force_relock_i in   1  single-cycle request to restart the PLL sequence
//  pll_rst_o      out  1  to PLL RST; active high
//  pll_locked_o   out  1  qualified lock indication
//  user_rst_n_o   out  1  active-low reset for logic clocked by the PLL outputs
//  fault_o        out  1  sticky: lock not achieved within MAX_RETRY attempts
//  retry_cnt_o    out  4  failed attempts since last success or force
//  state_o        out  3  current FSM state encoding, for debug
// BEHAVIOUR
//  Reset (rst_n=0): state=ASSERT, pll_rst_o=1, pll_locked_o=0, user_rst_n_o=0, fault_o=0, retry_cnt_o=0.
//   All counters are cleared. Release of rst_n is not synchronised inside the block.
//  lock_s: pll_lock_i passed through a 2-flop synchroniser. All decisions use lock_s.
//  All outputs are registered. One shared cycle counter cnt is sized by $clog2 of the largest parameter.
//  It clears on every state change.
//  States (state_o encoding): ASSERT=0, WAIT=1, QUAL=2, RELEASE=3, RUN=4, FAULT=5.
//  ASSERT:  pll_rst_o=1. When cnt==RST_PULSE_CYC-1, go to WAIT. pll_rst_o=0 from the WAIT cycle on.
//  WAIT:    if lock_s=1, go to QUAL.
//           Else if cnt==LOCK_TIMEOUT_CYC-1, the attempt fails:
//             retry+1; if the new value ==MAX_RETRY go to FAULT, else go to ASSERT.
//  QUAL:    if lock_s=0, the attempt fails (same rule as a WAIT timeout).
//           If cnt==LOCK_STABLE_CYC-1 with lock_s=1, go to RELEASE: pll_locked_o=1, retry=0.
//  RELEASE: if lock_s=0, go to ASSERT with pll_locked_o=0. This counts as a failed attempt.
//           If cnt==RELEASE_DLY_CYC-1, go to RUN: user_rst_n_o=1.
//  RUN:     if lock_s=0 (lock loss), go to ASSERT. On the next edge: user_rst_n_o=0, pll_locked_o=0, pll_rst_o=1.
//           retry stays 0, because loss after a good lock is not a failed attempt.
//  FAULT:   pll_rst_o=1, fault_o=1, user_rst_n_o=0, pll_locked_o=0. The state is sticky.
//           Only force_relock_i exits it.
//  force_relock_i=1 in any state: go to ASSERT, retry=0, fault_o=0, user_rst_n_o=0, pll_locked_o=0.
//   It has priority over every other transition in the same cycle.
//  Simultaneous timeout and lock_s rising in WAIT: lock wins, go to QUAL.
//  retry_cnt_o saturates at MAX_RETRY. It never wraps.
//  Invariants:
//   user_rst_n_o=1 only in RUN.
//   pll_locked_o=1 only in RELEASE or RUN.
//   pll_rst_o and user_rst_n_o are never both 1.
// TESTING
//  Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, LOCK_STABLE_CYC=8, MAX_RETRY=2, RELEASE_DLY_CYC=4.
//  1 Nominal: lock rises 20 cycles after pll_rst_o falls ->
//    pll_rst_o high exactly 4 cycles; pll_locked_o rises 2+8 cycles after lock;
//    user_rst_n_o rises 4 cycles after pll_locked_o; retry_cnt_o=0.
//  2 Timeout: lock held 0 ->
//    two reset pulses, 100 WAIT cycles each; then fault_o=1, state_o=5, retry_cnt_o=2, pll_rst_o stays 1.
//  3 Glitch in QUAL: lock high 5 cycles, low 1, then steady ->
//    retry_cnt_o=1, a new 4-cycle reset pulse, then normal release with retry_cnt_o=0.
//  4 Lock loss in RUN: drop pll_lock_i ->
//    user_rst_n_o=0 within 3 cycles, pll_rst_o=1, retry_cnt_o=0; re-lock repeats scenario 1 timing.
//  5 Recovery from FAULT: pulse force_relock_i while in FAULT ->
//    fault_o=0 next cycle, state_o=0, fresh sequence; lock supplied -> reaches RUN.
//  6 Async reset asserted mid-RUN ->
//    outputs immediately take their reset values, with no clock edge needed; force_relock_i in the same cycle is ignored.

Source files
------------

// File: rtl/pll_rst_sequencer.sv
// Sequences the PLL RST/LOCK handshake on the free-running oscillator clock.
// It qualifies lock, retries failed attempts, and releases a registered reset to the PLL-clocked logic.
module pll_rst_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 250000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 3,
    parameter int RELEASE_DLY_CYC  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       force_relock_i,
    output logic       pll_rst_o,
    output logic       pll_locked_o,
    output logic       user_rst_n_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CD  = (LOCK_STABLE_CYC > RELEASE_DLY_CYC) ? LOCK_STABLE_CYC : RELEASE_DLY_CYC;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DLY_CYC - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_WAIT    = 3'd1,
        ST_QUAL    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       retry, retry_next, retry_inc;
    logic             sync_ff, lock_s;

    // PLL lock is asynchronous to clk, so it is resynchronised before any decision uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync_ff <= pll_lock_i;
            lock_s  <= sync_ff;
        end
    end

    assign retry_inc = (retry >= RETRY_LIMIT) ? retry : retry + 4'd1;

    always_comb begin
        state_next = state;
        retry_next = retry;
        if (force_relock_i) begin
            state_next = ST_ASSERT;
            retry_next = 4'd0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == RST_LAST) state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state_next = ST_QUAL;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_next = retry_inc;
                        state_next = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_ASSERT;
                    end
                end
                ST_QUAL: begin
                    if (!lock_s) begin
                        retry_next = retry_inc;
                        state_next = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_ASSERT;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = ST_RELEASE;
                        retry_next = 4'd0;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        state_next = ST_ASSERT;
                        retry_next = retry_inc;
                    end else if (cnt == RELEASE_LAST) begin
                        state_next = ST_RUN;
                    end
                end
                // Losing lock after a good release restarts the PLL but is not a failed attempt.
                ST_RUN: begin
                    if (!lock_s) state_next = ST_ASSERT;
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_ASSERT;
                end
            endcase
        end
    end

    // A forced relock restarts the reset pulse even when already in ASSERT.
    always_comb begin
        cnt_next = cnt;
        if (state_next != state || force_relock_i) begin
            cnt_next = '0;
        end else if (state == ST_RUN || state == ST_FAULT) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ASSERT;
            cnt          <= '0;
            retry        <= 4'd0;
            pll_rst_o    <= 1'b1;
            pll_locked_o <= 1'b0;
            user_rst_n_o <= 1'b0;
            fault_o      <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            retry        <= retry_next;
            pll_rst_o    <= (state_next == ST_ASSERT) || (state_next == ST_FAULT);
            pll_locked_o <= (state_next == ST_RELEASE) || (state_next == ST_RUN);
            user_rst_n_o <= (state_next == ST_RUN);
            fault_o      <= (state_next == ST_FAULT);
        end
    end

    assign state_o     = state;
    assign retry_cnt_o = retry;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Bench for pll_rst_sequencer: directed PLL scenarios followed by randomized lock behaviour.
// Every cycle is compared against a timeline model that tracks the phase, its entry edge and the retry count.
module tb_pll_rst_sequencer;

    localparam int RST_PULSE = 4;
    localparam int TIMEOUT   = 100;
    localparam int STABLE    = 8;
    localparam int MAXR      = 2;
    localparam int RELDLY    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       force_relock_i = 1'b0;
    logic       pll_rst_o, pll_locked_o, user_rst_n_o, fault_o;
    logic [3:0] retry_cnt_o;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    // Phase numbers follow the debug encoding of state_o.
    int m_phase, m_entered, m_edge = 0, m_retries;
    bit m_sync1, m_lock_s;

    pll_rst_sequencer #(
        .RST_PULSE_CYC(RST_PULSE), .LOCK_TIMEOUT_CYC(TIMEOUT), .LOCK_STABLE_CYC(STABLE),
        .MAX_RETRY(MAXR), .RELEASE_DLY_CYC(RELDLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .force_relock_i(force_relock_i),
        .pll_rst_o(pll_rst_o), .pll_locked_o(pll_locked_o), .user_rst_n_o(user_rst_n_o),
        .fault_o(fault_o), .retry_cnt_o(retry_cnt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        m_phase   = 0;
        m_entered = m_edge;
        m_retries = 0;
        m_sync1   = 1'b0;
        m_lock_s  = 1'b0;
    endfunction

    function automatic void modelGo(input int p);
        m_phase   = p;
        m_entered = m_edge;
    endfunction

    function automatic void modelFail();
        if (m_retries < MAXR) m_retries = m_retries + 1;
        modelGo((m_retries == MAXR) ? 5 : 0);
    endfunction

    // elapsed counts full cycles spent in the current phase before this edge.
    function automatic void modelStep(input bit lk, input bit frc);
        int elapsed;
        m_edge++;
        elapsed = m_edge - m_entered - 1;
        if (frc) begin
            modelGo(0);
            m_retries = 0;
        end else begin
            case (m_phase)
                0: if (elapsed == RST_PULSE - 1) modelGo(1);
                1: if (m_lock_s) modelGo(2); else if (elapsed == TIMEOUT - 1) modelFail();
                2: if (!m_lock_s) modelFail();
                   else if (elapsed == STABLE - 1) begin modelGo(3); m_retries = 0; end
                3: if (!m_lock_s) begin
                       if (m_retries < MAXR) m_retries = m_retries + 1;
                       modelGo(0);
                   end else if (elapsed == RELDLY - 1) modelGo(4);
                4: if (!m_lock_s) modelGo(0);
                default: ;
            endcase
        end
        m_lock_s = m_sync1;
        m_sync1  = lk;
    endfunction

    task automatic checkAll();
        checkOutput("pll_rst", pll_rst_o, (m_phase == 0 || m_phase == 5));
        checkOutput("pll_locked", pll_locked_o, (m_phase == 3 || m_phase == 4));
        checkOutput("user_rst_n", user_rst_n_o, (m_phase == 4));
        checkOutput("fault", fault_o, (m_phase == 5));
        checkOutput("retry_cnt", retry_cnt_o, m_retries);
        checkOutput("state", state_o, m_phase);
    endtask

    task automatic applyStimulus(input bit lk, input bit frc);
        pll_lock_i     = lk;
        force_relock_i = frc;
        @(posedge clk);
        modelStep(lk, frc);
        #1;
        checkAll();
    endtask

    // Emulates a PLL: lock rises 'delay' cycles after RST falls (never if negative),
    // optionally with one low glitch of drop_len cycles starting drop_after cycles after lock.
    task automatic runPll(input int cycles, input int delay, input int drop_after,
                          input int drop_len, input bit rand_force);
        int since = 0;
        bit armed = (drop_after >= 0);
        bit lk, frc;
        repeat (cycles) begin
            if (m_phase == 0 || m_phase == 5) since = 0; else since++;
            lk = (delay >= 0 && since >= delay);
            if (armed && delay >= 0 && since >= delay + drop_after) begin
                if (since < delay + drop_after + drop_len) lk = 1'b0;
                else armed = 1'b0;
            end
            frc = rand_force && ($urandom_range(0, 199) == 0);
            applyStimulus(lk, frc);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pll_rst"}, pll_rst_o, 1);
        checkOutput({tag, "_pll_locked"}, pll_locked_o, 0);
        checkOutput({tag, "_user_rst_n"}, user_rst_n_o, 0);
        checkOutput({tag, "_fault"}, fault_o, 0);
        checkOutput({tag, "_retry"}, retry_cnt_o, 0);
        checkOutput({tag, "_state"}, state_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        modelReset();

        $display("[TB] nominal lock");
        runPll(60, 20, -1, 0, 1'b0);
        checkOutput("nominal_state", state_o, 4);
        checkOutput("nominal_user_rst_n", user_rst_n_o, 1);
        checkOutput("nominal_retry", retry_cnt_o, 0);

        $display("[TB] lock loss in RUN");
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("loss_user_rst_n", user_rst_n_o, 0);
        checkOutput("loss_pll_rst", pll_rst_o, 1);
        checkOutput("loss_retry", retry_cnt_o, 0);
        runPll(60, 20, -1, 0, 1'b0);
        checkOutput("relock_state", state_o, 4);

        $display("[TB] timeout to fault");
        runPll(240, -1, -1, 0, 1'b0);
        checkOutput("timeout_fault", fault_o, 1);
        checkOutput("timeout_state", state_o, 5);
        checkOutput("timeout_retry", retry_cnt_o, 2);
        checkOutput("timeout_pll_rst", pll_rst_o, 1);

        $display("[TB] force relock out of fault");
        applyStimulus(1'b0, 1'b1);
        checkOutput("force_fault", fault_o, 0);
        checkOutput("force_state", state_o, 0);
        runPll(60, 20, -1, 0, 1'b0);
        checkOutput("force_run_state", state_o, 4);

        $display("[TB] glitch during qualification");
        applyStimulus(1'b1, 1'b1);
        runPll(90, 20, 5, 1, 1'b0);
        checkOutput("glitch_state", state_o, 4);
        checkOutput("glitch_retry", retry_cnt_o, 0);

        $display("[TB] async reset in RUN");
        #2;
        rst_n          = 1'b0;
        force_relock_i = 1'b1;
        #1;
        checkResetValues("async");
        @(posedge clk);
        #1;
        checkResetValues("async_held");
        rst_n          = 1'b1;
        force_relock_i = 1'b0;
        modelReset();
        runPll(60, 20, -1, 0, 1'b0);
        checkOutput("async_run_state", state_o, 4);

        $display("[TB] randomized segments");
        for (int s = 0; s < 20; s++) begin
            int d, da;
            d  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 110));
            da = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
            runPll($urandom_range(150, 300), d, da, $urandom_range(1, 4), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
